// File: rtl/bnn_apb_regfile_if.sv
// APB3 bus bundle for the BNN accelerator register file.
// The master drives the request; the slave returns ready, read data and error.
interface bnn_apb_regfile_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic              pready;
  logic [31:0]       prdata;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/bnn_apb_regfile.sv
// APB3 control/status register file for the BNN systolic accelerator:
// config registers, start pulses, sticky done/start_err status and a level interrupt.
module bnn_apb_regfile #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ROW_W      = 5,
  parameter int unsigned COL_W      = 5,
  parameter int unsigned ACT_ADDR_W = 11,
  parameter int unsigned BATCH_W    = 6,
  parameter logic [31:0] VERSION    = 32'h0002_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  bnn_apb_regfile_if.slave      s_apb,
  input  logic                  array_busy,
  input  logic                  array_done,
  output logic                  weight_transfer,
  output logic                  systolic_start,
  output logic [ROW_W-1:0]      last_row,
  output logic [COL_W-1:0]      last_col,
  output logic [ACT_ADDR_W-1:0] activations_addr_start,
  output logic [BATCH_W-1:0]    batch,
  output logic                  irq
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_LAST_ROW = 3'd1;
  localparam logic [2:0] OFF_LAST_COL = 3'd2;
  localparam logic [2:0] OFF_ACT_ADDR = 3'd3;
  localparam logic [2:0] OFF_BATCH    = 3'd4;
  localparam logic [2:0] OFF_STATUS   = 3'd5;
  localparam logic [2:0] OFF_IRQ_EN   = 3'd6;
  localparam logic [2:0] OFF_VERSION  = 3'd7;

  logic                  r_weight_transfer;
  logic                  r_systolic_start;
  logic [ROW_W-1:0]      r_last_row;
  logic [COL_W-1:0]      r_last_col;
  logic [ACT_ADDR_W-1:0] r_act_addr;
  logic [BATCH_W-1:0]    r_batch;
  logic                  r_irq_en;
  logic                  r_done;
  logic                  r_start_err;
  logic                  r_irq;

  logic        w_access;
  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_off;
  logic        w_misalign;
  logic        w_start_rej;
  logic        w_err;
  logic        w_wr_ok;
  logic        w_ctrl_wr;
  logic        w_status_wr;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_access   = s_apb.psel & s_apb.penable;
  assign w_wr       = w_access & s_apb.pwrite;
  assign w_rd       = w_access & ~s_apb.pwrite;
  assign w_off      = s_apb.paddr[4:2];
  assign w_misalign = (s_apb.paddr[1:0] != 2'b00);

  // Only an aligned CTRL write can be a rejected start; misaligned accesses touch nothing.
  assign w_start_rej = w_wr & ~w_misalign & (w_off == OFF_CTRL) & s_apb.pwdata[1] & array_busy;
  assign w_err       = w_access & (w_misalign | (w_wr & (w_off == OFF_VERSION)) | w_start_rej);
  assign w_wr_ok     = w_wr & ~w_err;
  assign w_ctrl_wr   = w_wr_ok & (w_off == OFF_CTRL);
  assign w_status_wr = w_wr_ok & (w_off == OFF_STATUS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_weight_transfer <= 1'b0;
      r_systolic_start  <= 1'b0;
      r_last_row        <= '0;
      r_last_col        <= '0;
      r_act_addr        <= '0;
      r_batch           <= '0;
      r_irq_en          <= 1'b0;
      r_done            <= 1'b0;
      r_start_err       <= 1'b0;
      r_irq             <= 1'b0;
    end else begin
      r_weight_transfer <= w_ctrl_wr & s_apb.pwdata[0];
      r_systolic_start  <= w_ctrl_wr & s_apb.pwdata[1];
      if (w_wr_ok) begin
        case (w_off)
          OFF_LAST_ROW: r_last_row <= s_apb.pwdata[ROW_W-1:0];
          OFF_LAST_COL: r_last_col <= s_apb.pwdata[COL_W-1:0];
          OFF_ACT_ADDR: r_act_addr <= s_apb.pwdata[ACT_ADDR_W-1:0];
          OFF_BATCH:    r_batch    <= s_apb.pwdata[BATCH_W-1:0];
          OFF_IRQ_EN:   r_irq_en   <= s_apb.pwdata[0];
          default:      ;
        endcase
      end
      // Set beats W1C when both land on the same edge.
      r_done      <= array_done  | (r_done      & ~(w_status_wr & s_apb.pwdata[1]));
      r_start_err <= w_start_rej | (r_start_err & ~(w_status_wr & s_apb.pwdata[2]));
      r_irq       <= r_irq_en & (r_done | r_start_err);
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    if (w_rd && !w_err) begin
      case (w_off)
        OFF_LAST_ROW: w_rdata = 32'(r_last_row);
        OFF_LAST_COL: w_rdata = 32'(r_last_col);
        OFF_ACT_ADDR: w_rdata = 32'(r_act_addr);
        OFF_BATCH:    w_rdata = 32'(r_batch);
        OFF_STATUS:   w_rdata = {29'h0, r_start_err, r_done, array_busy};
        OFF_IRQ_EN:   w_rdata = {31'h0, r_irq_en};
        OFF_VERSION:  w_rdata = VERSION;
        default:      w_rdata = 32'h0;
      endcase
    end
  end

  // Bus responses are forced low while reset is asserted so an aborted access is silent.
  assign s_apb.pready  = resetn & w_access;
  assign s_apb.pslverr = resetn & w_err;
  assign s_apb.prdata  = resetn ? w_rdata : 32'h0;

  assign weight_transfer        = r_weight_transfer;
  assign systolic_start         = r_systolic_start;
  assign last_row               = r_last_row;
  assign last_col               = r_last_col;
  assign activations_addr_start = r_act_addr;
  assign batch                  = r_batch;
  assign irq                    = r_irq;

  assign w_unused = ^{s_apb.paddr, s_apb.pwdata};

endmodule

// File: tb/tb_bnn_apb_regfile.sv
// Randomised self-checking bench for bnn_apb_regfile against a register-map level model.
module tb_bnn_apb_regfile;

  localparam logic [31:0] VERSION = 32'h0002_0000;

  logic       clk = 1'b0;
  logic       resetn;
  logic       array_busy;
  logic       array_done;
  logic       weight_transfer;
  logic       systolic_start;
  logic [4:0] last_row;
  logic [4:0] last_col;
  logic [10:0] activations_addr_start;
  logic [5:0] batch;
  logic       irq;

  bnn_apb_regfile_if #(.ADDR_W(32)) apb ();

  bnn_apb_regfile dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .s_apb                  (apb),
    .array_busy             (array_busy),
    .array_done             (array_done),
    .weight_transfer        (weight_transfer),
    .systolic_start         (systolic_start),
    .last_row               (last_row),
    .last_col               (last_col),
    .activations_addr_start (activations_addr_start),
    .batch                  (batch),
    .irq                    (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: stored register values by word offset plus sticky bits.
  logic [31:0] m_reg [8];
  logic [31:0] m_mask [8];
  logic        m_done;
  logic        m_serr;
  int          m_wt_cnt;
  int          m_ss_cnt;
  int          seen_wt;
  int          seen_ss;

  always @(negedge clk) begin
    if (resetn) begin
      if (weight_transfer) seen_wt++;
      if (systolic_start)  seen_ss++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return 32'h0;
      3'd5:    return {29'h0, m_serr, m_done, array_busy};
      3'd7:    return VERSION;
      default: return m_reg[off];
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
    m_done = 1'b0;
    m_serr = 1'b0;
  endtask

  // One full APB transfer starting one time unit after a rising edge; leaves the bus idle
  // one unit after the completing edge so calls chain back-to-back.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic done_pulse, output logic [31:0] rd, output logic err);
    logic [2:0]  off;
    logic        aligned;
    logic        reject;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        exp_wt;
    logic        exp_ss;
    off     = addr[4:2];
    aligned = (addr[1:0] == 2'b00);
    reject  = wr && aligned && off == 3'd0 && wd[1] && array_busy;
    exp_err = !aligned || (wr && off == 3'd7) || reject;
    exp_rd  = (!wr && !exp_err) ? model_read(off) : 32'h0;

    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = wd;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    array_done  = done_pulse;
    #3;
    rd  = apb.prdata;
    err = apb.pslverr;
    check_eq("pready", {31'h0, apb.pready}, 32'h1);
    check_eq("pslverr", {31'h0, err}, {31'h0, exp_err});
    check_eq("prdata", rd, exp_rd);
    check_eq("irq", {31'h0, irq}, {31'h0, m_reg[6][0] & (m_done | m_serr)});
    @(posedge clk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    array_done  = 1'b0;

    exp_wt = wr && !exp_err && off == 3'd0 && wd[0];
    exp_ss = wr && !exp_err && off == 3'd0 && wd[1];
    if (wr && !exp_err) begin
      if (off == 3'd5) begin
        if (wd[1]) m_done = 1'b0;
        if (wd[2]) m_serr = 1'b0;
      end else if (off != 3'd0) begin
        m_reg[off] = wd & m_mask[off];
      end
    end
    if (reject)     m_serr = 1'b1;
    if (done_pulse) m_done = 1'b1;
    if (exp_wt) m_wt_cnt++;
    if (exp_ss) m_ss_cnt++;

    check_eq("weight_transfer", {31'h0, weight_transfer}, {31'h0, exp_wt});
    check_eq("systolic_start", {31'h0, systolic_start}, {31'h0, exp_ss});
    check_eq("last_row", 32'(last_row), m_reg[1]);
    check_eq("last_col", 32'(last_col), m_reg[2]);
    check_eq("act_addr", 32'(activations_addr_start), m_reg[3]);
    check_eq("batch", 32'(batch), m_reg[4]);
  endtask

  logic [31:0] rd;
  logic        err;

  initial begin
    m_mask[0] = 32'h0;    m_mask[1] = 32'h1F;  m_mask[2] = 32'h1F; m_mask[3] = 32'h7FF;
    m_mask[4] = 32'h3F;   m_mask[5] = 32'h0;   m_mask[6] = 32'h1;  m_mask[7] = 32'h0;
    model_reset();
    m_wt_cnt = 0; m_ss_cnt = 0; seen_wt = 0; seen_ss = 0;
    resetn = 1'b0; array_busy = 1'b0; array_done = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check_eq("rst_irq", {31'h0, irq}, 32'h0);

    for (int i = 1; i < 8; i++) xfer(1'b0, 32'(i * 4), 32'h0, 1'b0, rd, err);
    xfer(1'b0, 32'h1C, 32'h0, 1'b0, rd, err);
    check_eq("version_const", rd, 32'h0002_0000);

    xfer(1'b1, 32'h04, 32'hFFFF_FFFF, 1'b0, rd, err);
    check_eq("last_row_max", 32'(last_row), 32'h1F);
    xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, err);
    check_eq("last_row_rb", rd, 32'h1F);
    xfer(1'b1, 32'h0C, 32'h7FF, 1'b0, rd, err);
    check_eq("act_addr_max", 32'(activations_addr_start), 32'h7FF);

    xfer(1'b1, 32'h00, 32'h3, 1'b0, rd, err);
    check_eq("both_pulses", {30'h0, weight_transfer, systolic_start}, 32'h3);
    xfer(1'b0, 32'h00, 32'h0, 1'b0, rd, err);

    array_busy = 1'b1;
    xfer(1'b1, 32'h18, 32'h1, 1'b0, rd, err);
    xfer(1'b1, 32'h00, 32'h2, 1'b0, rd, err);
    check_eq("rej_err", {31'h0, err}, 32'h1);
    xfer(1'b0, 32'h14, 32'h0, 1'b0, rd, err);
    check_eq("status_rej", rd, 32'h5);
    check_eq("irq_rej", {31'h0, irq}, 32'h1);
    array_busy = 1'b0;
    xfer(1'b1, 32'h14, 32'h4, 1'b0, rd, err);
    xfer(1'b0, 32'h14, 32'h0, 1'b0, rd, err);
    check_eq("irq_fall", {31'h0, irq}, 32'h0);

    xfer(1'b1, 32'h14, 32'h0, 1'b1, rd, err);
    xfer(1'b1, 32'h14, 32'h2, 1'b1, rd, err);
    xfer(1'b0, 32'h14, 32'h0, 1'b0, rd, err);
    check_eq("done_set_wins", rd & 32'h2, 32'h2);

    xfer(1'b1, 32'h1C, 32'h1234, 1'b0, rd, err);
    check_eq("ver_wr_err", {31'h0, err}, 32'h1);
    xfer(1'b0, 32'h1C, 32'h0, 1'b0, rd, err);
    xfer(1'b1, 32'h05, 32'hFFFF_FFFF, 1'b0, rd, err);
    check_eq("misalign_err", {31'h0, err}, 32'h1);
    xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, err);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 8) a = 32'(sel * 4);
      else a = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(1, 3))};
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FFE0);
      array_busy = 1'($urandom_range(0, 1));
      xfer(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 7) == 0), rd, err);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    array_busy = 1'b0;

    // Build visible state, then pull reset in the middle of an ACCESS cycle.
    xfer(1'b1, 32'h18, 32'h1, 1'b0, rd, err);
    xfer(1'b1, 32'h04, 32'h0A, 1'b1, rd, err);
    xfer(1'b0, 32'h14, 32'h0, 1'b0, rd, err);
    check_eq("irq_pre_rst", {31'h0, irq}, 32'h1);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 32'h08;
    apb.pwdata = 32'h15;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_pready", {31'h0, apb.pready}, 32'h0);
    check_eq("rst_pslverr", {31'h0, apb.pslverr}, 32'h0);
    check_eq("rst_prdata", apb.prdata, 32'h0);
    check_eq("rst_outs", {5'(last_row), 5'(last_col), 11'(activations_addr_start), 6'(batch),
             weight_transfer, systolic_start, irq}, 32'h0);
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    model_reset();
    xfer(1'b0, 32'h08, 32'h0, 1'b0, rd, err);
    xfer(1'b0, 32'h18, 32'h0, 1'b0, rd, err);
    xfer(1'b0, 32'h14, 32'h0, 1'b0, rd, err);
    repeat (2) @(posedge clk);
    #1;
    check_eq("wt_pulse_count", 32'(seen_wt), 32'(m_wt_cnt));
    check_eq("ss_pulse_count", 32'(seen_ss), 32'(m_ss_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
